uart_tx_stream_arbiter: RTL

//  Shares the single UART TX byte stream among NUM_SRC AXI-Stream byte sources.

---
 rtl/uart_tx_stream_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_tx_stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream byte sources onto one
// UART TX stream, optionally prefixing each packet with a source-ID header byte.
module uart_tx_stream_arbiter #(
  parameter int         NUM_SRC     = 4,
  parameter bit         HDR_EN      = 1'b1,
  parameter logic [7:0] SRC_ID_BASE = 8'hA0,
  localparam int        IDX_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_SRC-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]     s_tvalid,
  output logic [NUM_SRC-1:0]     s_tready,
  input  logic [NUM_SRC-1:0]     s_tlast,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [15:0]            pkt_count
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             data_fire;

  // Scan starting just after the last-served source so every requester gets a turn.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_SRC;
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign data_fire = (state == DATA) && s_tvalid[grant_idx] && m_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDX_W'(NUM_SRC - 1);
      pkt_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            state     <= HDR_EN ? HDR : DATA;
          end
        end
        HDR: begin
          if (m_tready) state <= DATA;
        end
        DATA: begin
          if (data_fire && s_tlast[grant_idx]) begin
            rr_ptr    <= grant_idx;
            pkt_count <= pkt_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: header is a constant per grant; data is pure pass-through so m_tvalid never sees m_tready.
  always_comb begin
    m_tvalid    = 1'b0;
    m_tdata     = 8'd0;
    m_tlast     = 1'b0;
    s_tready    = '0;
    grant_valid = (state != IDLE);
    case (state)
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = SRC_ID_BASE + 8'(grant_idx);
      end
      DATA: begin
        m_tvalid            = s_tvalid[grant_idx];
        m_tdata             = s_tdata[8*grant_idx +: 8];
        m_tlast             = s_tlast[grant_idx];
        s_tready[grant_idx] = m_tready;
      end
      default: ;
    endcase
  end

endmodule
